// File: rtl/multicycle_sequencer_if.sv
// Control bundle between the multicycle sequencer and its datapath.
// master = sequencer side, slave = datapath side.
interface multicycle_sequencer_if;
  logic [5:0] opCode;
  logic       MOC;
  logic       zero;
  logic       marLoad;
  logic       mdrLoad;
  logic       instRegLoad;
  logic       pcLoad;
  logic       pcSrcBranch;
  logic       pcSrcJump;
  logic       memEnable;
  logic       RW;
  logic       regWrite;
  logic       regDst;
  logic       memToReg;
  logic       flagLoad;
  logic [1:0] aluSrc;
  logic [5:0] aluCode;
  logic [3:0] state;
  logic       illegal;
  logic       busErr;

  modport master (
    input  opCode, MOC, zero,
    output marLoad, mdrLoad, instRegLoad, pcLoad, pcSrcBranch, pcSrcJump,
           memEnable, RW, regWrite, regDst, memToReg, flagLoad,
           aluSrc, aluCode, state, illegal, busErr
  );

  modport slave (
    output opCode, MOC, zero,
    input  marLoad, mdrLoad, instRegLoad, pcLoad, pcSrcBranch, pcSrcJump,
           memEnable, RW, regWrite, regDst, memToReg, flagLoad,
           aluSrc, aluCode, state, illegal, busErr
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Control FSM for a multicycle CPU datapath: fetch, decode, execute, memory
// and write-back phases, with a bounded memory wait and sticky error states.
module multicycle_sequencer (
  input  logic                   Clk,
  input  logic                   Reset,
  multicycle_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    FETCH_MAR = 4'd0,
    FETCH_RD  = 4'd1,
    FETCH_IR  = 4'd2,
    DECODE    = 4'd3,
    EXEC_R    = 4'd4,
    EXEC_I    = 4'd5,
    MEM_ADDR  = 4'd6,
    MEM_RD    = 4'd7,
    MEM_WR    = 4'd8,
    WB        = 4'd9,
    BRANCH    = 4'd10,
    JUMP      = 4'd11,
    ILLEGAL   = 4'd12,
    BUS_ERR   = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_e     state_q, state_d;
  logic       rst_hold_q;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic [5:0] op_q, op_d;
  logic       illegal_q, illegal_d;
  logic       bus_err_q, bus_err_d;
  logic       in_wait_s;
  logic       entering_wait_s;

  // rst_hold_q keeps outputs idle for the cycle after Reset is released, so
  // FETCH_MAR becomes visible only on the first edge that sees Reset low.
  // State register, memory wait counter, latched opcode and sticky flags
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= FETCH_MAR;
      rst_hold_q <= 1'b1;
      wait_cnt_q <= 4'd0;
      op_q       <= 6'd0;
      illegal_q  <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rst_hold_q <= 1'b0;
      wait_cnt_q <= wait_cnt_d;
      op_q       <= op_d;
      illegal_q  <= illegal_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // Next-state logic, opcode latch and wait-counter update
  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    in_wait_s       = 1'b0;
    entering_wait_s = 1'b0;
    if (rst_hold_q) begin
      state_d = FETCH_MAR;
    end else begin
      case (state_q)
        FETCH_MAR: state_d = FETCH_RD;
        FETCH_RD: begin
          in_wait_s = 1'b1;
          if (bus.MOC) begin
            state_d = FETCH_IR;
          end else if (wait_cnt_q == 4'd15) begin
            state_d = BUS_ERR;
          end else begin
            state_d = FETCH_RD;
          end
        end
        FETCH_IR: state_d = DECODE;
        DECODE: begin
          op_d = bus.opCode;
          case (bus.opCode)
            OP_RTYPE:         state_d = EXEC_R;
            OP_ADDI, OP_ADDIU: state_d = EXEC_I;
            OP_LW, OP_SW:     state_d = MEM_ADDR;
            OP_BEQ:           state_d = BRANCH;
            OP_J:             state_d = JUMP;
            default:          state_d = ILLEGAL;
          endcase
        end
        EXEC_R: state_d = WB;
        EXEC_I: state_d = WB;
        MEM_ADDR: begin
          if (op_q == OP_LW) begin
            state_d = MEM_RD;
          end else if (op_q == OP_SW) begin
            state_d = MEM_WR;
          end else begin
            state_d = FETCH_MAR;
          end
        end
        MEM_RD: begin
          in_wait_s = 1'b1;
          if (bus.MOC) begin
            state_d = WB;
          end else if (wait_cnt_q == 4'd15) begin
            state_d = BUS_ERR;
          end else begin
            state_d = MEM_RD;
          end
        end
        MEM_WR: begin
          in_wait_s = 1'b1;
          if (bus.MOC) begin
            state_d = FETCH_MAR;
          end else if (wait_cnt_q == 4'd15) begin
            state_d = BUS_ERR;
          end else begin
            state_d = MEM_WR;
          end
        end
        WB:      state_d = FETCH_MAR;
        BRANCH:  state_d = FETCH_MAR;
        JUMP:    state_d = FETCH_MAR;
        ILLEGAL: state_d = ILLEGAL;
        BUS_ERR: state_d = BUS_ERR;
        default: state_d = FETCH_MAR;
      endcase
    end

    if ((state_d != state_q) &&
        ((state_d == FETCH_RD) || (state_d == MEM_RD) || (state_d == MEM_WR))) begin
      entering_wait_s = 1'b1;
    end else begin
      entering_wait_s = 1'b0;
    end

    if (entering_wait_s) begin
      wait_cnt_d = 4'd0;
    end else if (in_wait_s && !bus.MOC) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end

    illegal_d = illegal_q | (state_d == ILLEGAL);
    bus_err_d = bus_err_q | (state_d == BUS_ERR);
  end

  // Moore output decode; BRANCH alone qualifies its PC strobes with zero
  always_comb begin
    bus.marLoad     = 1'b0;
    bus.mdrLoad     = 1'b0;
    bus.instRegLoad = 1'b0;
    bus.pcLoad      = 1'b0;
    bus.pcSrcBranch = 1'b0;
    bus.pcSrcJump   = 1'b0;
    bus.memEnable   = 1'b0;
    bus.RW          = 1'b0;
    bus.regWrite    = 1'b0;
    bus.regDst      = 1'b0;
    bus.memToReg    = 1'b0;
    bus.flagLoad    = 1'b0;
    bus.aluSrc      = 2'b11;
    bus.aluCode     = 6'b111111;
    bus.state       = state_q;
    bus.illegal     = illegal_q;
    bus.busErr      = bus_err_q;
    if (rst_hold_q) begin
      bus.state = 4'd0;
    end else begin
      case (state_q)
        FETCH_MAR: bus.marLoad = 1'b1;
        FETCH_RD, MEM_RD: begin
          bus.memEnable = 1'b1;
          bus.RW        = 1'b1;
          bus.mdrLoad   = 1'b1;
        end
        FETCH_IR: begin
          bus.instRegLoad = 1'b1;
          bus.pcLoad      = 1'b1;
          bus.aluSrc      = 2'b10;
          bus.aluCode     = 6'b100000;
        end
        EXEC_R: begin
          bus.aluSrc   = 2'b00;
          bus.aluCode  = 6'b000000;
          bus.flagLoad = 1'b1;
          bus.regDst   = 1'b1;
        end
        EXEC_I: begin
          bus.aluSrc   = 2'b01;
          bus.aluCode  = 6'b100000;
          bus.flagLoad = (op_q != OP_ADDIU);
        end
        MEM_ADDR: begin
          bus.aluSrc  = 2'b01;
          bus.aluCode = 6'b100000;
          bus.marLoad = 1'b1;
        end
        MEM_WR: begin
          bus.memEnable = 1'b1;
          bus.RW        = 1'b0;
        end
        WB: begin
          bus.regWrite = 1'b1;
          bus.regDst   = (op_q == OP_RTYPE);
          bus.memToReg = (op_q == OP_LW);
        end
        BRANCH: begin
          bus.aluSrc      = 2'b00;
          bus.aluCode     = 6'b100010;
          bus.pcLoad      = bus.zero;
          bus.pcSrcBranch = bus.zero;
        end
        JUMP: begin
          bus.pcLoad    = 1'b1;
          bus.pcSrcJump = 1'b1;
        end
        default: bus.marLoad = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized scoreboard bench for multicycle_sequencer: an instruction-level
// model expands each instruction into its expected per-cycle outputs.
module tb_multicycle_sequencer;

  logic Clk = 1'b0;
  logic Reset;

  multicycle_sequencer_if bus ();

  multicycle_sequencer dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0] st;
    logic       moc;
    logic       z;
    logic [5:0] op;
    logic [5:0] iop;
    logic       rst;
    logic       idle;
  } cyc_t;

  cyc_t        plan[$];
  logic [25:0] sb[$];
  int          checks = 0;
  int          errors = 0;
  logic        ill_m = 1'b0;
  logic        berr_m = 1'b0;
  logic [5:0]  cur_iop = 6'd0;

  localparam logic [25:0] IDLE_REC = {12'd0, 2'b11, 6'b111111, 4'd0, 1'b0, 1'b0};

  // Expected control word for one cycle of a given state of an instruction
  function automatic logic [19:0] exp_ctrl(input logic [3:0] st, input logic [5:0] iop, input logic z);
    logic mar = 1'b0, mdr = 1'b0, ir = 1'b0, pcl = 1'b0, pcb = 1'b0, pcj = 1'b0;
    logic me = 1'b0, rw = 1'b0, rgw = 1'b0, rd = 1'b0, m2r = 1'b0, fl = 1'b0;
    logic [1:0] asrc = 2'b11;
    logic [5:0] acode = 6'b111111;
    case (st)
      4'd0:  mar = 1'b1;
      4'd1:  begin me = 1'b1; rw = 1'b1; mdr = 1'b1; end
      4'd2:  begin ir = 1'b1; pcl = 1'b1; asrc = 2'b10; acode = 6'b100000; end
      4'd4:  begin asrc = 2'b00; acode = 6'b000000; fl = 1'b1; rd = 1'b1; end
      4'd5:  begin asrc = 2'b01; acode = 6'b100000; fl = (iop != 6'b001001); end
      4'd6:  begin asrc = 2'b01; acode = 6'b100000; mar = 1'b1; end
      4'd7:  begin me = 1'b1; rw = 1'b1; mdr = 1'b1; end
      4'd8:  me = 1'b1;
      4'd9:  begin rgw = 1'b1; rd = (iop == 6'b000000); m2r = (iop == 6'b100011); end
      4'd10: begin asrc = 2'b00; acode = 6'b100010; pcl = z; pcb = z; end
      4'd11: begin pcl = 1'b1; pcj = 1'b1; end
      default: mar = 1'b0;
    endcase
    return {mar, mdr, ir, pcl, pcb, pcj, me, rw, rgw, rd, m2r, fl, asrc, acode};
  endfunction

  function automatic cyc_t mk(input logic [3:0] st, input logic moc);
    cyc_t c;
    c.st   = st;
    c.moc  = moc;
    c.z    = 1'($urandom_range(0, 1));
    c.op   = 6'($urandom_range(0, 63));
    c.iop  = cur_iop;
    c.rst  = 1'b0;
    c.idle = 1'b0;
    return c;
  endfunction

  function automatic cyc_t mk_idle(input logic rst);
    cyc_t c;
    c      = mk(4'd0, 1'($urandom_range(0, 1)));
    c.rst  = rst;
    c.idle = 1'b1;
    return c;
  endfunction

  // Drive one cycle's inputs and post that cycle's expected outputs
  task automatic step(input cyc_t c);
    @(posedge Clk);
    #1;
    Reset      = c.rst;
    bus.MOC    = c.moc;
    bus.zero   = c.z;
    bus.opCode = c.op;
    if (c.idle) begin
      ill_m  = 1'b0;
      berr_m = 1'b0;
      sb.push_back(IDLE_REC);
    end else begin
      if (c.st == 4'd12) ill_m = 1'b1;
      if (c.st == 4'd13) berr_m = 1'b1;
      sb.push_back({exp_ctrl(c.st, c.iop, c.z), c.st, ill_m, berr_m});
    end
  endtask

  // A memory wait of d MOC-low cycles; d > 15 times out; returns 1 on timeout
  function automatic bit add_wait(input logic [3:0] st, input int d);
    for (int i = 0; i < 16; i++) begin
      if (i == d) begin
        plan.push_back(mk(st, 1'b1));
        return 1'b0;
      end
      plan.push_back(mk(st, 1'b0));
    end
    plan.push_back(mk(4'd13, 1'($urandom_range(0, 1))));
    return 1'b1;
  endfunction

  task automatic run_instr(input logic [5:0] op, input int df, input int dm,
                           input logic z, input int abort_at);
    cyc_t c;
    bit   term;
    int   k;
    plan.delete();
    cur_iop = op;
    plan.push_back(mk(4'd0, 1'($urandom_range(0, 1))));
    term = add_wait(4'd1, df);
    if (!term) begin
      plan.push_back(mk(4'd2, 1'($urandom_range(0, 1))));
      c = mk(4'd3, 1'($urandom_range(0, 1)));
      c.op = op;
      plan.push_back(c);
      case (op)
        6'b000000: begin plan.push_back(mk(4'd4, 1'b1)); plan.push_back(mk(4'd9, 1'b1)); end
        6'b001000, 6'b001001: begin plan.push_back(mk(4'd5, 1'b0)); plan.push_back(mk(4'd9, 1'b0)); end
        6'b100011: begin
          plan.push_back(mk(4'd6, 1'b1));
          term = add_wait(4'd7, dm);
          if (!term) plan.push_back(mk(4'd9, 1'b1));
        end
        6'b101011: begin
          plan.push_back(mk(4'd6, 1'b1));
          term = add_wait(4'd8, dm);
        end
        6'b000100: begin c = mk(4'd10, 1'b1); c.z = z; plan.push_back(c); end
        6'b000010: plan.push_back(mk(4'd11, 1'b1));
        default: begin plan.push_back(mk(4'd12, 1'b1)); term = 1'b1; end
      endcase
    end
    if (term) begin
      for (int i = 0; i < 3; i++) plan.push_back(mk(plan[plan.size() - 1].st, 1'($urandom_range(0, 1))));
      k = plan.size() - 1;
    end else begin
      k = (abort_at >= 0 && abort_at < plan.size()) ? abort_at : -1;
    end
    if (k >= 0) begin
      while (plan.size() > k + 1) void'(plan.pop_back());
      c = plan.pop_back();
      c.rst = 1'b1;
      plan.push_back(c);
      repeat ($urandom_range(0, 2)) plan.push_back(mk_idle(1'b1));
      plan.push_back(mk_idle(1'b0));
    end
    foreach (plan[i]) step(plan[i]);
  endtask

  function automatic int rand_delay();
    int r;
    r = $urandom_range(0, 19);
    if (r < 16) return $urandom_range(0, 4);
    if (r == 16) return 14;
    if (r < 19) return 15;
    return 16;
  endfunction

  // Scoreboard monitor: one expected record per cycle, checked mid-cycle
  always @(negedge Clk) begin
    logic [25:0] exp_v;
    logic [25:0] got_v;
    if (sb.size() > 0) begin
      exp_v = sb.pop_front();
      got_v = {bus.marLoad, bus.mdrLoad, bus.instRegLoad, bus.pcLoad, bus.pcSrcBranch,
               bus.pcSrcJump, bus.memEnable, bus.RW, bus.regWrite, bus.regDst,
               bus.memToReg, bus.flagLoad, bus.aluSrc, bus.aluCode, bus.state,
               bus.illegal, bus.busErr};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL outputs at %0t: state got %0d required %0d, word got %h required %h",
                 $time, got_v[5:2], exp_v[5:2], got_v, exp_v);
      end
    end
  end

  initial begin
    logic [5:0] legal_ops [7];
    logic [5:0] op;
    legal_ops  = '{6'b000000, 6'b001000, 6'b001001, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
    Reset      = 1'b1;
    bus.MOC    = 1'b0;
    bus.zero   = 1'b0;
    bus.opCode = 6'd0;
    repeat (2) @(posedge Clk);
    step(mk_idle(1'b1));
    step(mk_idle(1'b0));

    run_instr(6'b000000, 0, 0, 1'b0, -1);
    run_instr(6'b100011, 0, 3, 1'b0, -1);
    run_instr(6'b101011, 1, 0, 1'b0, -1);
    run_instr(6'b000100, 0, 0, 1'b1, -1);
    run_instr(6'b000100, 0, 0, 1'b0, -1);
    run_instr(6'b000010, 2, 0, 1'b0, -1);
    run_instr(6'b001000, 0, 0, 1'b0, -1);
    run_instr(6'b001001, 0, 0, 1'b0, -1);
    run_instr(6'b000000, 16, 0, 1'b0, -1);
    run_instr(6'b000000, 15, 0, 1'b0, -1);
    run_instr(6'b100011, 0, 15, 1'b0, -1);
    run_instr(6'b101011, 0, 16, 1'b0, -1);
    run_instr(6'b111111, 0, 0, 1'b0, -1);
    run_instr(6'b100011, 5, 4, 1'b0, 8);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) == 0) op = 6'($urandom_range(0, 63));
      else op = legal_ops[$urandom_range(0, 6)];
      run_instr(op, rand_delay(), rand_delay(), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 12)) : -1);
    end

    @(posedge Clk);
    @(negedge Clk);
    @(negedge Clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d records left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
